// File: rtl/memory_stage.sv
// memory_stage: M stage of the 5-stage RV32 pipeline.
//
// Takes the E/M register outputs and issues word loads and stores on a
// request/response data-memory port. While an access is outstanding the
// stage holds StallM high so the hazard unit freezes the front of the
// pipeline. It also registers the M/W stage that feeds the writeback mux.
//
// Ports
//   CLK, RESET              clock (rising edge), asynchronous active-low reset
//   RegWriteM .. ALUResultM E/M pipeline register outputs
//   DMEM_REQ/WE/ADDR/WDATA  request side of the data-memory port
//   DMEM_READY              memory accepts the request this cycle
//   DMEM_RVALID/RDATA       load response
//   StallM                  freeze PC, F/D, D/E and E/M
//   *W                      M/W pipeline register outputs
//   MisalignW               access dropped because address[1:0] != 0
//   BusErrW                 access aborted on timeout
module memory_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        RegWriteM,
  input  logic        MemWriteM,
  input  logic [1:0]  ResultSrcM,
  input  logic [4:0]  RdM,
  input  logic [31:0] PCPlus4M,
  input  logic [31:0] WriteDataM,
  input  logic [31:0] ALUResultM,
  output logic        DMEM_REQ,
  output logic        DMEM_WE,
  output logic [31:0] DMEM_ADDR,
  output logic [31:0] DMEM_WDATA,
  input  logic        DMEM_READY,
  input  logic        DMEM_RVALID,
  input  logic [31:0] DMEM_RDATA,
  output logic        StallM,
  output logic        RegWriteW,
  output logic [1:0]  ResultSrcW,
  output logic [4:0]  RdW,
  output logic [31:0] PCPlus4W,
  output logic [31:0] ALUResultW,
  output logic [31:0] ReadDataW,
  output logic        MisalignW,
  output logic        BusErrW
);

  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t           state;
  state_t           nextState;
  logic [CNT_W-1:0] stallCnt;

  logic access;
  logic aligned;
  logic misalignDrop;
  logic timeoutHit;
  logic reqComb;
  logic stallComb;
  logic completeLoad;
  logic abortAccess;

  assign access       = MemWriteM | (ResultSrcM == 2'b01);
  assign aligned      = (ALUResultM[1:0] == 2'b00);
  assign misalignDrop = (state == IDLE) & access & ~aligned;

  // stallCnt counts the stalled cycles of the current access, including
  // the IDLE cycle that issued it, so the abort lands after TIMEOUT-1
  // stalled cycles. The >= also covers a load accepted on its last cycle.
  assign timeoutHit = (stallCnt >= CNT_W'(TIMEOUT - 1));

  // E/M is frozen during a stall, so the request fields pass straight through.
  assign DMEM_ADDR  = ALUResultM;
  assign DMEM_WDATA = WriteDataM;
  assign DMEM_WE    = MemWriteM;

  // Gated by RESET so a reset mid-access drops the request and the stall
  // without waiting for a clock edge.
  assign DMEM_REQ = reqComb & RESET;
  assign StallM   = stallComb & RESET;

  always_comb begin
    nextState    = state;
    reqComb      = 1'b0;
    stallComb    = 1'b0;
    completeLoad = 1'b0;
    abortAccess  = 1'b0;
    case (state)
      IDLE: begin
        if (access && aligned) begin
          reqComb = 1'b1;
          if (DMEM_READY) begin
            // Stores finish in the accept cycle; loads wait for data.
            if (!MemWriteM) begin
              stallComb = 1'b1;
              nextState = WAIT;
            end
          end else begin
            stallComb = 1'b1;
            nextState = REQ;
          end
        end
      end
      REQ: begin
        if (DMEM_READY) begin
          reqComb = 1'b1;
          if (MemWriteM) begin
            nextState = IDLE;
          end else begin
            stallComb = 1'b1;
            nextState = WAIT;
          end
        end else if (timeoutHit) begin
          abortAccess = 1'b1;
          nextState   = IDLE;
        end else begin
          reqComb   = 1'b1;
          stallComb = 1'b1;
        end
      end
      WAIT: begin
        if (DMEM_RVALID) begin
          completeLoad = 1'b1;
          nextState    = IDLE;
        end else if (timeoutHit) begin
          abortAccess = 1'b1;
          nextState   = IDLE;
        end else begin
          stallComb = 1'b1;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // M/W stage boundary
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state      <= IDLE;
      stallCnt   <= '0;
      RegWriteW  <= 1'b0;
      ResultSrcW <= 2'b00;
      RdW        <= 5'd0;
      PCPlus4W   <= 32'd0;
      ALUResultW <= 32'd0;
      ReadDataW  <= 32'd0;
      MisalignW  <= 1'b0;
      BusErrW    <= 1'b0;
    end else begin
      state    <= nextState;
      stallCnt <= stallComb ? stallCnt + CNT_W'(1) : '0;
      if (stallComb) begin
        // Bubble: kill the write and flags, hold the payload fields.
        RegWriteW <= 1'b0;
        MisalignW <= 1'b0;
        BusErrW   <= 1'b0;
      end else begin
        RegWriteW  <= RegWriteM & ~misalignDrop & ~abortAccess;
        ResultSrcW <= ResultSrcM;
        RdW        <= RdM;
        PCPlus4W   <= PCPlus4M;
        ALUResultW <= ALUResultM;
        ReadDataW  <= completeLoad ? DMEM_RDATA : 32'd0;
        MisalignW  <= misalignDrop;
        BusErrW    <= abortAccess;
      end
    end
  end

endmodule
